// File: rtl/otp_stream_cypher_pkg.sv
// Shared definitions for the one-time-pad stream cypher: default word width,
// FSM state encodings and the pad FIFO control bundle.
package otp_stream_cypher_pkg;

  localparam int MSG_SIZE = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WIPE = 1'b1
  } otp_state_e;

  // wr/rd are handshakes; wipe zeroes the entry at wipe_idx; wipe_last also resets pointers and level.
  typedef struct packed {
    logic wr;
    logic rd;
    logic wipe;
    logic wipe_last;
  } pad_ctl_t;

endpackage

// File: rtl/otp_pad_fifo.sv
// Key pad storage: circular buffer whose consumed entries are cleared on read,
// plus an indexed wipe port used by zeroize.
module otp_pad_fifo
  import otp_stream_cypher_pkg::*;
#(
  parameter int DATA_W    = MSG_SIZE,
  parameter int PAD_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  pad_ctl_t                     ctl,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [$clog2(PAD_DEPTH)-1:0] wipe_idx,
  output logic [DATA_W-1:0]            rd_data,
  output logic [$clog2(PAD_DEPTH):0]   level
);

  localparam int AW = $clog2(PAD_DEPTH);
  localparam int LW = AW + 1;

  logic [PAD_DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                    level_q, level_d;

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (ctl.wipe) begin
      mem_d[wipe_idx] = '0;
      if (ctl.wipe_last) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
      end
    end else begin
      if (ctl.wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      // A used pad word must never linger in storage.
      if (ctl.rd) begin
        mem_d[rd_ptr_q] = '0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      level_d = level_q + LW'(ctl.wr) - LW'(ctl.rd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/otp_stream_cypher.sv
// One-time-pad encryptor/decryptor: each message word is XORed with one fresh
// pad word; zeroize sweeps the whole pad to zero over PAD_DEPTH cycles.
module otp_stream_cypher
  import otp_stream_cypher_pkg::*;
#(
  parameter int DATA_W    = MSG_SIZE,
  parameter int PAD_DEPTH = 8,   // power of two, >= 2
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_valid,
  output logic                       key_ready,
  input  logic [DATA_W-1:0]          key_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       zeroize,
  output logic                       busy,
  output logic [$clog2(PAD_DEPTH):0] pad_level,
  output logic [CNT_W-1:0]           words_done
);

  localparam int AW = $clog2(PAD_DEPTH);
  localparam int LW = AW + 1;

  otp_state_e        state_q, state_d;
  logic [AW-1:0]     wipe_idx_q, wipe_idx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  words_q, words_d;
  pad_ctl_t          ctl;
  logic [DATA_W-1:0] pad_word;
  logic [LW-1:0]     level;

  otp_pad_fifo #(
    .DATA_W   (DATA_W),
    .PAD_DEPTH(PAD_DEPTH)
  ) u_pad (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctl     (ctl),
    .wr_data (key_data),
    .wipe_idx(wipe_idx_q),
    .rd_data (pad_word),
    .level   (level)
  );

  always_comb begin
    state_d     = state_q;
    wipe_idx_d  = wipe_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    words_d     = words_q;
    ctl         = '0;
    // Ready terms depend only on registered state and out_ready, never on the valids.
    key_ready   = (state_q == ST_RUN) && (level != LW'(PAD_DEPTH));
    in_ready    = (state_q == ST_RUN) && (level != '0) && (!out_valid_q || out_ready);
    busy        = (state_q == ST_WIPE);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      if (words_q != '1) words_d = words_q + 1'b1;
    end

    case (state_q)
      ST_RUN: begin
        ctl.wr = key_valid && key_ready;
        ctl.rd = in_valid && in_ready;
        if (ctl.rd) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data ^ pad_word;
        end
        if (zeroize) begin
          state_d     = ST_WIPE;
          wipe_idx_d  = '0;
          out_valid_d = 1'b0;
          out_data_d  = '0;
        end
      end
      ST_WIPE: begin
        ctl.wipe      = 1'b1;
        ctl.wipe_last = (wipe_idx_q == AW'(PAD_DEPTH - 1));
        wipe_idx_d    = wipe_idx_q + 1'b1;
        if (ctl.wipe_last) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wipe_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      wipe_idx_q  <= wipe_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      words_q     <= words_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pad_level  = level;
  assign words_done = words_q;

endmodule

// File: tb/tb_otp_stream_cypher.sv
// Directed bench for otp_stream_cypher with hand-computed expectations.
module tb_otp_stream_cypher;

  localparam int DW = 32;
  localparam int PD = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0, key_ready;
  logic [DW-1:0] key_data = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          zeroize = 1'b0, busy;
  logic [3:0]    pad_level;
  logic [CW-1:0] words_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  otp_stream_cypher #(.DATA_W(DW), .PAD_DEPTH(PD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .zeroize(zeroize), .busy(busy), .pad_level(pad_level), .words_done(words_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_key(input logic [DW-1:0] k);
    int t = 0;
    key_valid = 1'b1; key_data = k;
    while (!key_ready && t < 50) begin step(); t++; end
    if (t == 50) chk("key_timeout", key_ready, 1'b1);
    step();
    key_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int t = 0;
    in_valid = 1'b1; in_data = d;
    while (!in_ready && t < 50) begin step(); t++; end
    if (t == 50) chk("in_timeout", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    logic [DW-1:0] acc = '0;
    for (int i = 0; i < PD; i++) acc |= dut.u_pad.mem_q[i];
    chk({tag, "_key_ready"}, key_ready, 1'b1);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pad_level"}, pad_level, 0);
    chk({tag, "_words_done"}, words_done, 0);
    chk({tag, "_pad_zero"}, acc, 0);
  endtask

  function automatic logic [DW-1:0] kw(input int i);
    return 32'hC3C3_0000 | i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, t;
    logic [DW-1:0] acc;

    // reset state
    step(); step();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // basic encrypt: 12345678^A5A5A5A5 = B791F3DD, FFFFFFFF^0F0F0F0F = F0F0F0F0
    push_key(32'hA5A5_A5A5);
    push_key(32'h0F0F_0F0F);
    chk("lvl2", pad_level, 2);
    send_word(32'h1234_5678);
    chk("ov1", out_valid, 1'b1);
    chk("out1", out_data, 32'hB791_F3DD);
    send_word(32'hFFFF_FFFF);
    chk("out2", out_data, 32'hF0F0_F0F0);
    step();
    chk("done2", words_done, 2);
    chk("lvl0", pad_level, 0);
    chk("inrdy0", in_ready, 1'b0);

    // fill, then simultaneous write+consume across the pointer wrap
    for (int i = 0; i < PD; i++) push_key(kw(i));
    chk("full_lvl", pad_level, PD);
    chk("full_krdy", key_ready, 1'b0);
    send_word(32'h0);
    chk("wrap_k0", out_data, kw(0));
    chk("lvl7", pad_level, 7);
    key_valid = 1'b1; key_data = kw(8);
    in_valid = 1'b1; in_data = 32'h0;
    step();
    key_valid = 1'b0; in_valid = 1'b0;
    chk("simul_lvl", pad_level, 7);
    chk("simul_k1", out_data, kw(1));
    for (int i = 2; i <= 8; i++) begin
      send_word(32'h0);
      chk($sformatf("order_k%0d", i), out_data, kw(i));
    end
    step();
    chk("drain_lvl", pad_level, 0);
    chk("done11", words_done, 11);

    // backpressure: 0BADF00D^0000FFFF = 0BAD0FF2, 5555AAAA^FFFF0000 = AAAAAAAA
    push_key(32'h0BAD_F00D);
    push_key(32'h5555_AAAA);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_FFFF;
    step();
    in_data = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_hold", out_data, 32'h0BAD_0FF2);
      chk("bp_inrdy", in_ready, 1'b0);
      step();
    end
    chk("bp_lvl", pad_level, 1);
    out_ready = 1'b1;
    #1;
    chk("bp_release", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_out2", out_data, 32'hAAAA_AAAA);
    step();
    chk("done13", words_done, 13);

    // zeroize with a pending output; a second pulse mid-wipe must be ignored
    push_key(32'h1111_1111);
    push_key(32'h2222_2222);
    push_key(32'h3333_3333);
    out_ready = 1'b0;
    send_word(32'h0000_1234);
    chk("pend_ov", out_valid, 1'b1);
    chk("pend_lvl", pad_level, 2);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    chk("zero_drop", out_valid, 1'b0);
    bc = 0; t = 0;
    while (busy && t < 20) begin
      bc++; t++;
      zeroize = (bc == 3);
      step();
      zeroize = 1'b0;
    end
    chk("busy_len", bc, PD);
    acc = '0;
    for (int i = 0; i < PD; i++) acc |= dut.u_pad.mem_q[i];
    chk("wipe_pad_zero", acc, 0);
    chk("wipe_lvl", pad_level, 0);
    chk("wipe_krdy", key_ready, 1'b1);
    chk("wipe_done_kept", words_done, 13);
    out_ready = 1'b1;
    push_key(32'hCAFE_BABE);
    send_word(32'h0);
    chk("post_wipe_out", out_data, 32'hCAFE_BABE);
    step();

    // reset asserted mid-wipe
    push_key(32'h4444_4444);
    push_key(32'h5555_5555);
    push_key(32'h6666_6666);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    step(); step();
    chk("midwipe_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rel_busy", busy, 1'b0);
    chk("rel_krdy", key_ready, 1'b1);

    // saturation of a 4-bit counter over 20 words
    for (int i = 0; i < 20; i++) begin
      push_key(32'h0101_0101 * i);
      send_word(i);
    end
    step();
    chk("sat15", words_done, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
